// File: rtl/ife_block_dep_scoreboard.sv
// ife_block_dep_scoreboard
//   Registered, handshaked dependence check for one instruction block per cycle.
//   Flags RAW/WAW/WAR hazards between lanes of the block, RAW/WAW hazards against
//   the write sets of previously dispatched blocks (scoreboard tags), and
//   side-effecting opcodes. Safe results allocate a scoreboard tag on handshake;
//   the backend frees tags with retire and clears everything with flush.
//
//   Optional build macro: IFE_DEP_STATS_EN adds saturating safe/unsafe result
//   counters (stat_safe_o / stat_unsafe_o).
//
// Ports
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   blk_valid_i / blk_ready_o   input block handshake
//   instrs_i, lane_valid_i      block instructions (lane 0 oldest) and lane valids
//   res_valid_o / res_ready_i   result handshake
//   res_safe_o, res_cause_o     verdict; cause = {no tag, side effect, in-flight, intra}
//   res_lane_haz_o              lanes responsible for intra/in-flight hazards
//   res_tag_o                   tag that a safe result allocates on handshake
//   retire_valid_i/retire_tag_i free one scoreboard tag
//   flush_i                     free all tags and drop the pending result
//   inflight_cnt_o              number of allocated tags
module ife_block_dep_scoreboard #(
    parameter int  INSTR_WIDTH    = 32,
    parameter int  REG_ADDR_WIDTH = 5,
    parameter int  BLOCK_SIZE     = 4,
    parameter int  MAX_INFLIGHT   = 4,
    localparam int NREG           = 2 ** REG_ADDR_WIDTH,
    localparam int TW             = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              blk_valid_i,
    output logic                              blk_ready_o,
    input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] instrs_i,
    input  logic [BLOCK_SIZE-1:0]             lane_valid_i,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic                              res_safe_o,
    output logic [3:0]                        res_cause_o,
    output logic [BLOCK_SIZE-1:0]             res_lane_haz_o,
    output logic [TW-1:0]                     res_tag_o,
    input  logic                              retire_valid_i,
    input  logic [TW-1:0]                     retire_tag_i,
    input  logic                              flush_i,
    output logic [TW:0]                       inflight_cnt_o
`ifdef IFE_DEP_STATS_EN
    ,
    output logic [31:0]                       stat_safe_o,
    output logic [31:0]                       stat_unsafe_o
`endif
);

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;

    function automatic logic op_writes_rd(input logic [6:0] op);
        return (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

    function automatic logic op_reads_rs1(input logic [6:0] op);
        return (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
    endfunction

    function automatic logic op_reads_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_REG32) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic op_side_effect(input logic [6:0] op);
        return (op == OP_SYSTEM) || (op == OP_MISC) || (op == OP_STORE);
    endfunction

    // State
    logic                  res_valid_q, res_valid_d;
    logic                  res_safe_q, res_safe_d;
    logic [3:0]            res_cause_q, res_cause_d;
    logic [BLOCK_SIZE-1:0] res_haz_q, res_haz_d;
    logic [TW-1:0]         res_tag_q, res_tag_d;
    logic [NREG-1:0]       res_mask_q, res_mask_d;
    logic [MAX_INFLIGHT-1:0] busy_q, busy_d;
    logic [NREG-1:0]       mask_q [MAX_INFLIGHT];
    logic [NREG-1:0]       mask_d [MAX_INFLIGHT];
    logic [TW:0]           cnt_q, cnt_d;

    // Funct3/funct7 are irrelevant to the check; folded here so every input bit is consumed.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instrs_i;

    // Lane decode. Register fields equal to x0 are treated as unused so x0 never hazards.
    logic [6:0]                op_a  [BLOCK_SIZE];
    logic [REG_ADDR_WIDTH-1:0] rd_a  [BLOCK_SIZE];
    logic [REG_ADDR_WIDTH-1:0] rs1_a [BLOCK_SIZE];
    logic [REG_ADDR_WIDTH-1:0] rs2_a [BLOCK_SIZE];
    logic [BLOCK_SIZE-1:0]     rdw, r1u, r2u, side_lane;

    always_comb begin
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            op_a[i]      = instrs_i[i*INSTR_WIDTH +: 7];
            rd_a[i]      = instrs_i[i*INSTR_WIDTH+7 +: REG_ADDR_WIDTH];
            rs1_a[i]     = instrs_i[i*INSTR_WIDTH+15 +: REG_ADDR_WIDTH];
            rs2_a[i]     = instrs_i[i*INSTR_WIDTH+20 +: REG_ADDR_WIDTH];
            rdw[i]       = lane_valid_i[i] && op_writes_rd(op_a[i]) && (rd_a[i] != '0);
            r1u[i]       = lane_valid_i[i] && op_reads_rs1(op_a[i]) && (rs1_a[i] != '0);
            r2u[i]       = lane_valid_i[i] && op_reads_rs2(op_a[i]) && (rs2_a[i] != '0);
            side_lane[i] = lane_valid_i[i] && op_side_effect(op_a[i]);
        end
    end

    // Hazard evaluation of the incoming block against the current state.
    logic [NREG-1:0]         wset, blk_mask;
    logic [BLOCK_SIZE-1:0]   lane_haz;
    logic                    intra_hit, infl_hit;
    logic [MAX_INFLIGHT-1:0] tag_free;
    logic                    any_free;
    logic [TW-1:0]           free_tag;

    always_comb begin
        // A pending safe result is about to allocate, so its writes count as in flight.
        wset = (res_valid_q && res_safe_q) ? res_mask_q : '0;
        for (int t = 0; t < MAX_INFLIGHT; t++) begin
            if (busy_q[t]) wset = wset | mask_q[t];
        end
        lane_haz  = '0;
        intra_hit = 1'b0;
        infl_hit  = 1'b0;
        blk_mask  = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (rdw[i]) blk_mask[rd_a[i]] = 1'b1;
            for (int j = 0; j < i; j++) begin
                if ((r1u[i] && rdw[j] && (rs1_a[i] == rd_a[j])) ||
                    (r2u[i] && rdw[j] && (rs2_a[i] == rd_a[j])) ||
                    (rdw[i] && rdw[j] && (rd_a[i] == rd_a[j])) ||
                    (rdw[i] && r1u[j] && (rd_a[i] == rs1_a[j])) ||
                    (rdw[i] && r2u[j] && (rd_a[i] == rs2_a[j]))) begin
                    lane_haz[i] = 1'b1;
                    intra_hit   = 1'b1;
                end
            end
            if ((rdw[i] && wset[rd_a[i]]) || (r1u[i] && wset[rs1_a[i]]) ||
                (r2u[i] && wset[rs2_a[i]])) begin
                lane_haz[i] = 1'b1;
                infl_hit    = 1'b1;
            end
        end
        // The pending safe result's tag is reserved: it allocates in this same cycle.
        tag_free = ~busy_q;
        for (int t = 0; t < MAX_INFLIGHT; t++) begin
            if (res_valid_q && res_safe_q && (res_tag_q == TW'(t))) tag_free[t] = 1'b0;
        end
        any_free = 1'b0;
        free_tag = '0;
        for (int t = MAX_INFLIGHT - 1; t >= 0; t--) begin
            if (tag_free[t]) begin
                any_free = 1'b1;
                free_tag = TW'(t);
            end
        end
    end

    logic accept, res_hs, alloc;
    assign blk_ready_o = !flush_i && (!res_valid_q || res_ready_i);
    assign accept      = blk_valid_i && blk_ready_o;
    assign res_hs      = res_valid_q && res_ready_i;
    assign alloc       = res_hs && res_safe_q;

    // Next state: result register, scoreboard, occupancy.
    always_comb begin
        res_valid_d = res_valid_q;
        res_safe_d  = res_safe_q;
        res_cause_d = res_cause_q;
        res_haz_d   = res_haz_q;
        res_tag_d   = res_tag_q;
        res_mask_d  = res_mask_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_cause_d = {!any_free, |side_lane, infl_hit, intra_hit};
            res_safe_d  = any_free && !(|side_lane) && !infl_hit && !intra_hit;
            res_haz_d   = lane_haz;
            res_tag_d   = free_tag;
            res_mask_d  = blk_mask;
        end else if (res_hs) begin
            res_valid_d = 1'b0;
        end

        busy_d = busy_q;
        mask_d = mask_q;
        // Free tags always hold a zero mask, so retiring one is naturally a no-op.
        for (int t = 0; t < MAX_INFLIGHT; t++) begin
            if (retire_valid_i && (retire_tag_i == TW'(t))) begin
                busy_d[t] = 1'b0;
                mask_d[t] = '0;
            end
        end
        // Applied after retire so allocation wins on a same-tag collision.
        for (int t = 0; t < MAX_INFLIGHT; t++) begin
            if (alloc && (res_tag_q == TW'(t))) begin
                busy_d[t] = 1'b1;
                mask_d[t] = res_mask_q;
            end
        end
        if (flush_i) begin
            res_valid_d = 1'b0;
            busy_d      = '0;
            for (int t = 0; t < MAX_INFLIGHT; t++) mask_d[t] = '0;
        end

        cnt_d = '0;
        for (int t = 0; t < MAX_INFLIGHT; t++) cnt_d = cnt_d + (TW+1)'(busy_d[t]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_safe_q  <= 1'b0;
            res_cause_q <= '0;
            res_haz_q   <= '0;
            res_tag_q   <= '0;
            res_mask_q  <= '0;
            busy_q      <= '0;
            cnt_q       <= '0;
            for (int t = 0; t < MAX_INFLIGHT; t++) mask_q[t] <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_safe_q  <= res_safe_d;
            res_cause_q <= res_cause_d;
            res_haz_q   <= res_haz_d;
            res_tag_q   <= res_tag_d;
            res_mask_q  <= res_mask_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            for (int t = 0; t < MAX_INFLIGHT; t++) mask_q[t] <= mask_d[t];
        end
    end

    assign res_valid_o    = res_valid_q;
    assign res_safe_o     = res_safe_q;
    assign res_cause_o    = res_cause_q;
    assign res_lane_haz_o = res_haz_q;
    assign res_tag_o      = res_tag_q;
    assign inflight_cnt_o = cnt_q;

`ifdef IFE_DEP_STATS_EN
    // Saturating counters of handshaked verdicts; flush does not clear them.
    logic [31:0] stat_safe_q, stat_safe_d, stat_unsafe_q, stat_unsafe_d;

    always_comb begin
        stat_safe_d   = stat_safe_q;
        stat_unsafe_d = stat_unsafe_q;
        if (res_hs && res_safe_q && (stat_safe_q != 32'hFFFF_FFFF))
            stat_safe_d = stat_safe_q + 32'd1;
        if (res_hs && !res_safe_q && (stat_unsafe_q != 32'hFFFF_FFFF))
            stat_unsafe_d = stat_unsafe_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_safe_q   <= '0;
            stat_unsafe_q <= '0;
        end else begin
            stat_safe_q   <= stat_safe_d;
            stat_unsafe_q <= stat_unsafe_d;
        end
    end

    assign stat_safe_o   = stat_safe_q;
    assign stat_unsafe_o = stat_unsafe_q;
`endif

endmodule

// File: tb/tb_ife_block_dep_scoreboard.sv
// Testbench for ife_block_dep_scoreboard: directed scenarios followed by random
// traffic, all compared against a set-based reference model of the scoreboard.
module tb_ife_block_dep_scoreboard;
    localparam int BS = 4;
    localparam int IW = 32;
    localparam int NT = 4;
    localparam int TW = 2;

    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] SYS   = 7'b1110011;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             blk_valid = 1'b0;
    logic             blk_ready_o;
    logic [BS*IW-1:0] instrs = '0;
    logic [BS-1:0]    lane_valid = '0;
    logic             res_valid_o;
    logic             res_ready = 1'b0;
    logic             res_safe_o;
    logic [3:0]       res_cause_o;
    logic [BS-1:0]    res_lane_haz_o;
    logic [TW-1:0]    res_tag_o;
    logic             retire_valid = 1'b0;
    logic [TW-1:0]    retire_tag = '0;
    logic             flush = 1'b0;
    logic [TW:0]      inflight_cnt_o;
`ifdef IFE_DEP_STATS_EN
    logic [31:0]      stat_safe_o, stat_unsafe_o;
`endif

    always #5 clk = ~clk;

    ife_block_dep_scoreboard dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .blk_valid_i    (blk_valid),
        .blk_ready_o    (blk_ready_o),
        .instrs_i       (instrs),
        .lane_valid_i   (lane_valid),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready),
        .res_safe_o     (res_safe_o),
        .res_cause_o    (res_cause_o),
        .res_lane_haz_o (res_lane_haz_o),
        .res_tag_o      (res_tag_o),
        .retire_valid_i (retire_valid),
        .retire_tag_i   (retire_tag),
        .flush_i        (flush),
        .inflight_cnt_o (inflight_cnt_o)
`ifdef IFE_DEP_STATS_EN
        ,
        .stat_safe_o    (stat_safe_o),
        .stat_unsafe_o  (stat_unsafe_o)
`endif
    );

    // Reference model: per-tag busy flag and written-register set, plus the pending result.
    bit        m_busy [NT];
    bit [31:0] m_mask [NT];
    bit        m_pv, m_psafe;
    bit [3:0]  m_pcause, m_phaz;
    int        m_ptag;
    bit [31:0] m_pmask;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
    endfunction

    task automatic set_block(input logic [31:0] l0, input logic [31:0] l1, input logic [31:0] l2,
                             input logic [31:0] l3, input logic [3:0] lv);
        instrs     = {l3, l2, l1, l0};
        lane_valid = lv;
        blk_valid  = 1'b1;
    endtask

    task automatic mreset();
        for (int t = 0; t < NT; t++) begin
            m_busy[t] = 1'b0;
            m_mask[t] = '0;
        end
        m_pv = 0; m_psafe = 0; m_pcause = 0; m_phaz = 0; m_ptag = 0; m_pmask = 0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int t = 0; t < NT; t++) c += int'(m_busy[t]);
        return c;
    endfunction

    task automatic check_all();
        chk("res_valid", 32'(res_valid_o), 32'(m_pv));
        chk("res_safe", 32'(res_safe_o), 32'(m_psafe));
        chk("res_cause", 32'(res_cause_o), 32'(m_pcause));
        chk("res_lane_haz", 32'(res_lane_haz_o), 32'(m_phaz));
        chk("res_tag", 32'(res_tag_o), 32'(m_ptag));
        chk("inflight_cnt", 32'(inflight_cnt_o), 32'(m_count()));
    endtask

    // One clock: inputs were driven after the previous falling edge.
    task automatic tick();
        bit        exp_ready, accept, hs, w, r1, r2;
        bit [31:0] wset, ow, orr, ins;
        bit [6:0]  op;
        int        rd, rs1, rs2, ntag;
        bit [3:0]  ncause, nhaz;
        #1;
        exp_ready = !flush && (!m_pv || res_ready);
        chk("blk_ready", 32'(blk_ready_o), 32'(exp_ready));
        accept = blk_valid && exp_ready;
        hs     = m_pv && res_ready;
        ncause = 0; nhaz = 0; ow = 0; orr = 0; ntag = -1;
        if (accept) begin
            wset = (m_pv && m_psafe) ? m_pmask : 32'd0;
            for (int t = 0; t < NT; t++) if (m_busy[t]) wset |= m_mask[t];
            for (int i = 0; i < BS; i++) begin
                if (lane_valid[i]) begin
                    ins = instrs[i*IW +: IW];
                    op  = ins[6:0];
                    rd  = int'(ins[11:7]);
                    rs1 = int'(ins[19:15]);
                    rs2 = int'(ins[24:20]);
                    w  = (op != STORE) && (op != BEQ) && (rd != 0);
                    r1 = !(op == LUI || op == 7'b0010111 || op == JAL) && (rs1 != 0);
                    r2 = (op == ADD || op == 7'b0111011 || op == STORE || op == BEQ) && (rs2 != 0);
                    if ((w && (ow[rd] || orr[rd])) || (r1 && ow[rs1]) || (r2 && ow[rs2])) begin
                        nhaz[i] = 1; ncause[0] = 1;
                    end
                    if ((w && wset[rd]) || (r1 && wset[rs1]) || (r2 && wset[rs2])) begin
                        nhaz[i] = 1; ncause[1] = 1;
                    end
                    if (op == SYS || op == 7'b0001111 || op == STORE) ncause[2] = 1;
                    if (w)  ow[rd] = 1;
                    if (r1) orr[rs1] = 1;
                    if (r2) orr[rs2] = 1;
                end
            end
            for (int t = 0; t < NT; t++)
                if (ntag < 0 && !m_busy[t] && !(m_pv && m_psafe && m_ptag == t)) ntag = t;
            if (ntag < 0) begin
                ncause[3] = 1;
                ntag = 0;
            end
        end
        if (flush) begin
            for (int t = 0; t < NT; t++) begin
                m_busy[t] = 0;
                m_mask[t] = 0;
            end
            m_pv = 0;
        end else begin
            if (retire_valid && m_busy[int'(retire_tag)]) begin
                m_busy[int'(retire_tag)] = 0;
                m_mask[int'(retire_tag)] = 0;
            end
            if (hs && m_psafe) begin
                m_busy[m_ptag] = 1;
                m_mask[m_ptag] = m_pmask;
            end
            if (accept) begin
                m_pv = 1; m_psafe = (ncause == 0); m_pcause = ncause;
                m_phaz = nhaz; m_ptag = ntag; m_pmask = ow;
            end else if (hs) begin
                m_pv = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        blk_valid = 0; retire_valid = 0; flush = 0; res_ready = 1;
    endtask

    task automatic retire(input int t);
        idle();
        retire_valid = 1;
        retire_tag = TW'(t);
        tick();
        retire_valid = 0;
    endtask

    logic [3:0]    hold_cause;
    logic [BS-1:0] hold_haz;
    logic [TW-1:0] hold_tag;
    logic [6:0]    ops [12];

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        mreset();
        @(negedge clk);
        check_all();
        chk("reset_ready", 32'(blk_ready_o), 32'd1);
        chk("reset_valid", 32'(res_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // Four independent writes: safe, tag 0, one tag allocated after handshake
        set_block(mk(ADDI, 1, 0, 0), mk(ADDI, 2, 0, 0), mk(ADDI, 3, 0, 0), mk(ADDI, 4, 0, 0), 4'b1111);
        tick();
        chk("t1_safe", 32'(res_safe_o), 32'd1);
        chk("t1_cause", 32'(res_cause_o), 32'd0);
        chk("t1_tag", 32'(res_tag_o), 32'd0);
        idle();
        tick();
        chk("t1_cnt", 32'(inflight_cnt_o), 32'd1);

        // Intra-block RAW on lane 2
        set_block(mk(ADDI, 5, 0, 0), mk(ADDI, 9, 0, 0), mk(ADD, 6, 5, 7), mk(ADDI, 10, 0, 0), 4'b1111);
        tick();
        chk("t2_cause", 32'(res_cause_o), 32'b0001);
        chk("t2_haz", 32'(res_lane_haz_o), 32'b0100);
        idle();
        tick();
        chk("t2_cnt", 32'(inflight_cnt_o), 32'd1);

        // Back-to-back: reader of x8 sees the pending result's write
        set_block(mk(ADDI, 8, 0, 0), 32'd0, 32'd0, 32'd0, 4'b0001);
        tick();
        set_block(mk(ADDI, 12, 0, 0), mk(ADD, 11, 8, 13), 32'd0, 32'd0, 4'b0011);
        tick();
        chk("t3_cause", 32'(res_cause_o), 32'b0010);
        chk("t3_haz", 32'(res_lane_haz_o), 32'b0010);
        idle();
        tick();
        retire(0);
        retire(1);
        chk("t3_cnt", 32'(inflight_cnt_o), 32'd0);

        // Fill all tags, fifth block finds none free, retire tag 2 and resend
        for (int k = 0; k < 5; k++) begin
            set_block(mk(ADDI, 16 + k, 0, 0), 32'd0, 32'd0, 32'd0, 4'b0001);
            tick();
            if (k < 4) chk("t4_tag", 32'(res_tag_o), 32'(k));
        end
        chk("t4_full_cause", 32'(res_cause_o), 32'b1000);
        idle();
        tick();
        chk("t4_cnt_full", 32'(inflight_cnt_o), 32'd4);
        retire(2);
        set_block(mk(ADDI, 20, 0, 0), 32'd0, 32'd0, 32'd0, 4'b0001);
        tick();
        chk("t4_resend_safe", 32'(res_safe_o), 32'd1);
        chk("t4_resend_tag", 32'(res_tag_o), 32'd2);
        idle();
        tick();
        for (int t = 0; t < NT; t++) retire(t);

        // Side effects: ecall, store; masked ecall lane is harmless
        set_block(mk(ADDI, 1, 0, 0), 32'h0000_0073, mk(ADDI, 3, 0, 0), mk(ADDI, 4, 0, 0), 4'b1111);
        tick();
        chk("t5_ecall_cause", 32'(res_cause_o), 32'b0100);
        chk("t5_ecall_safe", 32'(res_safe_o), 32'd0);
        set_block(mk(STORE, 0, 6, 5), 32'd0, 32'd0, 32'd0, 4'b0001);
        tick();
        chk("t5_sw_cause", 32'(res_cause_o), 32'b0100);
        set_block(mk(ADDI, 1, 0, 0), 32'h0000_0073, mk(ADDI, 3, 0, 0), mk(ADDI, 4, 0, 0), 4'b1101);
        tick();
        chk("t5_masked_safe", 32'(res_safe_o), 32'd1);
        idle();
        tick();

        // Backpressure then flush
        set_block(mk(ADDI, 9, 0, 0), 32'd0, 32'd0, 32'd0, 4'b0001);
        tick();
        hold_cause = res_cause_o; hold_haz = res_lane_haz_o; hold_tag = res_tag_o;
        res_ready = 0;
        set_block(mk(ADDI, 14, 0, 0), 32'd0, 32'd0, 32'd0, 4'b0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t6_hold_valid", 32'(res_valid_o), 32'd1);
            chk("t6_hold_tag", 32'(res_tag_o), 32'(hold_tag));
            chk("t6_hold_cause", 32'(res_cause_o), 32'(hold_cause));
            chk("t6_hold_haz", 32'(res_lane_haz_o), 32'(hold_haz));
            chk("t6_ready_low", 32'(blk_ready_o), 32'd0);
        end
        flush = 1;
        tick();
        chk("t6_flush_valid", 32'(res_valid_o), 32'd0);
        chk("t6_flush_cnt", 32'(inflight_cnt_o), 32'd0);

        // Asynchronous reset in the middle of a transfer
        idle();
        set_block(mk(ADDI, 7, 0, 0), 32'd0, 32'd0, 32'd0, 4'b0001);
        tick();
        idle();
        tick();
        set_block(mk(ADDI, 15, 0, 0), 32'd0, 32'd0, 32'd0, 4'b0001);
        tick();
        rst_n = 0;
        #1;
        chk("rst_valid", 32'(res_valid_o), 32'd0);
        chk("rst_safe", 32'(res_safe_o), 32'd0);
        chk("rst_cause", 32'(res_cause_o), 32'd0);
        chk("rst_haz", 32'(res_lane_haz_o), 32'd0);
        chk("rst_tag", 32'(res_tag_o), 32'd0);
        chk("rst_cnt", 32'(inflight_cnt_o), 32'd0);
        mreset();
        idle();
        @(negedge clk);
        rst_n = 1;

        // Random traffic against the model
        ops = '{ADDI, ADDI, ADDI, ADD, ADD, ADD, LUI, JAL, BEQ, STORE, SYS, ADDI};
        for (int n = 0; n < 500; n++) begin
            blk_valid = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < BS; i++)
                instrs[i*IW +: IW] = mk(ops[$urandom_range(0, 11)], int'($urandom_range(0, 7)),
                                        int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            lane_valid   = BS'($urandom_range(0, 15));
            res_ready    = ($urandom_range(0, 3) != 0);
            retire_valid = ($urandom_range(0, 3) == 0);
            retire_tag   = TW'($urandom_range(0, 3));
            flush        = ($urandom_range(0, 39) == 0);
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
